pixel_injector: RTL and testbench
=================================

Name: pixel_injector

Overview:
- Wishbone-controlled pixel injector; the write-side counterpart to the team's single-pixel capture probe.
- The probe reads one pixel at a programmed beat offset. This block overwrites one pixel at a programmed beat offset in a passing pixel stream.
- Sits inline on a video pixel bus for test-pattern insertion and capture-path self-test. Single clock domain.

Parameters:
- DW, 32, pixel data width (1..32).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset. One clock, i_clk. Reset is synchronous and active-high.
- i_wb_cyc  in  1  wishbone cycle.
- i_wb_stb  in  1  wishbone strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  2  register select.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  acknowledge.
- o_wb_stall  out  1  stall, tied 0.
- o_wb_data  out  32  read data.
- i_valid  in  1  input pixel beat valid.
- i_sync  in  1  frame start; qualified by i_valid.
- i_data  in  DW  input pixel.
- o_valid  out  1  output beat valid.
- o_sync  out  1  delayed i_sync.
- o_data  out  DW  output pixel, possibly replaced.

Behaviour:
- Register map:
  - 0 PERIOD, 32b.
  - 1 POSITION, 32b.
  - 2 PIXEL, DW bits; upper bits read 0.
  - 3 CTRL:
    - bit0 EN.
    - bit1 ONESHOT.
    - bit2 ARM: write 1 arms; reads ARMED.
    - bit3 DONE: sticky; write 1 clears.
    - [31:16] HITS: read-only.
- Reset values: all registers 0; HITS, ARMED, DONE 0; o_valid, o_sync, o_data, o_wb_ack, o_wb_data all 0.
- Wishbone:
  - o_wb_ack <= i_wb_cyc & i_wb_stb, one cycle after the strobe. Cleared by reset or by !i_wb_cyc.
  - o_wb_data is registered and updates on every strobed read.
  - A write is visible to a read in the next bus cycle.
  - Never stalls.
- Beat index idx (32b, reset 0): the index of the next valid beat.
  - Valid beat with i_sync: that beat has index 0, and idx <= 1.
  - Otherwise, when the beat's index == PERIOD-1 and PERIOD != 0: idx <= 0.
  - Otherwise: idx <= idx+1.
  - PERIOD == 0: free-running, wrapping at 2^32.
- Shadow registers pos_s and pix_s:
  - Loaded from POSITION and PIXEL on every valid beat whose index is 0, taking effect from index 1.
  - Also loaded every cycle while EN == 0.
  - Mid-frame register writes therefore never tear a frame.
- Hit: valid beat AND EN AND index == pos_s AND (!ONESHOT OR ARMED).
- Pipeline latency is exactly 1 cycle:
  - o_valid <= i_valid; o_sync <= i_sync & i_valid.
  - o_data <= hit ? pix_s : i_data.
  - o_data holds its value when i_valid is 0.
- One-shot FSM, active when ONESHOT = 1:
  - IDLE -(write ARM=1)-> ARMED.
  - ARMED -(hit)-> DONE_ST: ARMED cleared, DONE set.
  - DONE_ST -(write ARM=1)-> ARMED.
- Continuous mode (ONESHOT = 0): every hit injects; ARMED is ignored.
- HITS increments on each hit and saturates at 0xFFFF. Writing CTRL with bit3 = 1 clears both HITS and DONE.
- Simultaneous events:
  - ARM write in the same cycle as a hit: the hit uses the old ARMED; ARMED ends at 1.
  - DONE clear in the same cycle as a hit: set wins, DONE = 1 and HITS = 1.
- POSITION >= PERIOD (PERIOD != 0): no hit ever occurs; not an error.
- Reset mid-frame: idx returns to 0, and the next beat is index 0 regardless of i_sync.

Decomposition:
- Shared package pixinj_pkg holds:
  - Register address constants ADDR_PERIOD=0, ADDR_POSITION=1, ADDR_PIXEL=2, ADDR_CTRL=3.
  - CTRL bit positions EN=0, ONESHOT=1, ARM=2, DONE=3.
  - HITS_LSB=16.
  - FSM state enum.
- One sub-module, pixel_beat_counter: idx generation, sync and PERIOD wrap, and the index-0 strobe used for shadow load.

Test Plan:
1. PERIOD=8, POSITION=3, PIXEL=0xA5A5A5A5, EN=1, ONESHOT=0, continuous stream of valid beats with i_sync every 8 beats -> o_data = 0xA5A5A5A5 on the output beat one cycle after input beat index 3 of every frame; all other beats pass through; HITS counts per frame.
2. ONESHOT=1, ARM written, 3 frames -> exactly one injection, in the first frame after arm; CTRL reads ARMED=0, DONE=1, HITS=1. Re-arm -> one more injection, HITS=2.
3. POSITION changed from 3 to 5 mid-frame (after index 1) -> the current frame still injects at index 3; the next frame injects at index 5.
4. PERIOD=4 without i_sync, then i_sync asserted at index 2 -> idx restarts at 0 on the sync beat; the injection position follows the new frame alignment.
5. ARM write in the same cycle as a matching beat while ARMED=0 -> no injection on that beat; ARMED=1 afterwards; injection occurs in the next frame. DONE-clear coincident with a hit -> DONE=1.
6. Reset asserted mid-frame with i_valid gaps -> all outputs 0 on the following cycle; the first valid beat after reset gets index 0. Wishbone strobe with i_wb_cyc low -> no ack.

Source files
------------

// File: rtl/pixinj_pkg.sv
// Shared constants and types for the pixel injector.
package pixinj_pkg;

  // Wishbone register addresses
  localparam logic [1:0] ADDR_PERIOD   = 2'd0;
  localparam logic [1:0] ADDR_POSITION = 2'd1;
  localparam logic [1:0] ADDR_PIXEL    = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_ARM     = 2;
  localparam int CTRL_DONE    = 3;
  localparam int HITS_LSB     = 16;

  // One-shot arming state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } inj_state_t;

endpackage

// File: rtl/pixel_beat_counter.sv
// Beat index generator: sync restarts the frame, PERIOD wraps it,
// PERIOD == 0 free-runs over the full 32-bit range.
module pixel_beat_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        sync,
  input  logic [31:0] period,
  output logic [31:0] beat_idx,
  output logic        first_beat
);

  logic [31:0] idx;

  // A sync beat is index 0 regardless of where the counter stands
  assign beat_idx   = sync ? 32'd0 : idx;
  assign first_beat = valid && (beat_idx == 32'd0);

  // Advance the index of the next beat on every valid beat
  always_ff @(posedge clk) begin
    if (reset)
      idx <= '0;
    else if (valid) begin
      if (sync)
        idx <= 32'd1;
      else if (period != 32'd0 && idx == period - 32'd1)
        idx <= '0;
      else
        idx <= idx + 32'd1;
    end
  end

endmodule

// File: rtl/pixel_injector.sv
// Inline pixel injector: replaces one pixel per frame at a programmed
// beat offset, controlled over a pipelined Wishbone slave.
module pixel_injector
  import pixinj_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [31:0]   i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [31:0]   o_wb_data,
  input  logic          i_valid,
  input  logic          i_sync,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic          o_sync,
  output logic [DW-1:0] o_data
);

  logic [31:0]   period, position, pos_s, beat_idx, ctrl_rd;
  logic [DW-1:0] pixel, pix_s;
  logic          en, oneshot, done, armed, hit, first_beat;
  logic          bus_req, wr, ctrl_wr, arm_wr, clr_wr;
  logic [15:0]   hits, hits_base;
  inj_state_t    state;

  assign bus_req    = i_wb_cyc && i_wb_stb;
  assign wr         = bus_req && i_wb_we;
  assign ctrl_wr    = wr && (i_wb_addr == ADDR_CTRL);
  assign arm_wr     = ctrl_wr && i_wb_data[CTRL_ARM];
  assign clr_wr     = ctrl_wr && i_wb_data[CTRL_DONE];
  assign armed      = (state == ST_ARMED);
  assign o_wb_stall = 1'b0;

  // Hit compares against the shadowed position, so it never tears mid-frame
  assign hit = i_valid && en && (beat_idx == pos_s) && (!oneshot || armed);

  // A clear in the same cycle as a hit leaves the count at 1
  assign hits_base = clr_wr ? 16'd0 : hits;

  assign ctrl_rd = (32'(hits) << HITS_LSB) | {28'd0, done, armed, oneshot, en};

  pixel_beat_counter u_cnt (
    .clk       (i_clk),
    .reset     (i_reset),
    .valid     (i_valid),
    .sync      (i_sync),
    .period    (period),
    .beat_idx  (beat_idx),
    .first_beat(first_beat)
  );

  // Programmable registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      period   <= '0;
      position <= '0;
      pixel    <= '0;
      en       <= 1'b0;
      oneshot  <= 1'b0;
    end else if (wr) begin
      case (i_wb_addr)
        ADDR_PERIOD:   period   <= i_wb_data;
        ADDR_POSITION: position <= i_wb_data;
        ADDR_PIXEL:    pixel    <= i_wb_data[DW-1:0];
        default: begin
          en      <= i_wb_data[CTRL_EN];
          oneshot <= i_wb_data[CTRL_ONESHOT];
        end
      endcase
    end
  end

  // Registered bus response; read data only moves on strobed reads
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= bus_req;
      if (bus_req && !i_wb_we) begin
        case (i_wb_addr)
          ADDR_PERIOD:   o_wb_data <= period;
          ADDR_POSITION: o_wb_data <= position;
          ADDR_PIXEL:    o_wb_data <= 32'(pixel);
          default:       o_wb_data <= ctrl_rd;
        endcase
      end
    end
  end

  // Shadow copies: frame-aligned when enabled, transparent when disabled
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pos_s <= '0;
      pix_s <= '0;
    end else if (!en || first_beat) begin
      pos_s <= position;
      pix_s <= pixel;
    end
  end

  // One-shot FSM with sticky DONE and saturating hit counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      done  <= 1'b0;
      hits  <= '0;
    end else begin
      case (state)
        ST_ARMED: if (!arm_wr && hit && oneshot) state <= ST_DONE;
        default:  if (arm_wr) state <= ST_ARMED;
      endcase
      if (hit && oneshot)
        done <= 1'b1;
      else if (clr_wr)
        done <= 1'b0;
      hits <= (hit && hits_base != 16'hFFFF) ? hits_base + 16'd1 : hits_base;
    end
  end

  // One-cycle pixel pipeline; data holds across invalid cycles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= i_valid;
      o_sync  <= i_sync && i_valid;
      if (i_valid)
        o_data <= hit ? pix_s : i_data;
    end
  end

endmodule

// File: tb/tb_pixel_injector.sv
// Self-checking bench for pixel_injector with a per-cycle behavioural model.
module tb_pixel_injector;
  import pixinj_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [1:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;
  logic        i_valid = 1'b0, i_sync = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_valid, o_sync;
  logic [31:0] o_data;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] PIX = 32'hA5A5A5A5;

  pixel_injector #(.DW(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .i_valid(i_valid), .i_sync(i_sync), .i_data(i_data),
    .o_valid(o_valid), .o_sync(o_sync), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  // reference model state
  logic [31:0] m_period, m_position, m_pixel, m_idx, m_pos_s, m_pix_s;
  logic [15:0] m_hits;
  bit          m_en, m_oneshot, m_armed, m_done;
  logic [31:0] exp_data, exp_rd;
  bit          exp_valid, exp_sync, exp_ack;

  task automatic model_clear();
    m_period = 0; m_position = 0; m_pixel = 0; m_idx = 0; m_pos_s = 0; m_pix_s = 0;
    m_hits = 0; m_en = 0; m_oneshot = 0; m_armed = 0; m_done = 0;
    exp_data = 0; exp_rd = 0; exp_valid = 0; exp_sync = 0; exp_ack = 0;
  endtask

  // one clock: predict from the rules, drive, clock, leave outputs settled
  task automatic step(input bit v, input bit s, input logic [31:0] d,
                      input bit cyc, input bit stb, input bit we,
                      input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] bidx;
    bit hit, wr, cw;
    wr   = cyc && stb && we;
    cw   = wr && a == ADDR_CTRL;
    bidx = s ? 32'd0 : m_idx;
    hit  = v && m_en && bidx == m_pos_s && (!m_oneshot || m_armed);
    exp_ack = cyc && stb;
    if (cyc && stb && !we)
      case (a)
        ADDR_PERIOD:   exp_rd = m_period;
        ADDR_POSITION: exp_rd = m_position;
        ADDR_PIXEL:    exp_rd = m_pixel;
        default:       exp_rd = {m_hits, 12'd0, m_done, m_armed, m_oneshot, m_en};
      endcase
    exp_valid = v;
    exp_sync  = v && s;
    if (v) exp_data = hit ? m_pix_s : d;
    if (!m_en || (v && bidx == 0)) begin m_pos_s = m_position; m_pix_s = m_pixel; end
    if (v) m_idx = s ? 32'd1 : (m_period != 0 && bidx == m_period - 1) ? 32'd0 : bidx + 1;
    if (cw && wd[3]) begin m_hits = 0; m_done = 0; end
    if (hit) begin
      if (m_hits != 16'hFFFF) m_hits = m_hits + 1;
      if (m_oneshot) begin m_done = 1; m_armed = 0; end
    end
    if (cw && wd[2]) m_armed = 1;
    if (wr)
      case (a)
        ADDR_PERIOD:   m_period = wd;
        ADDR_POSITION: m_position = wd;
        ADDR_PIXEL:    m_pixel = wd;
        default: begin m_en = wd[0]; m_oneshot = wd[1]; end
      endcase
    i_valid = v; i_sync = s; i_data = d;
    i_wb_cyc = cyc; i_wb_stb = stb; i_wb_we = we; i_wb_addr = a; i_wb_data = wd;
    @(posedge i_clk); #1;
  endtask

  task automatic beat(input bit s, input logic [31:0] d);
    step(1, s, d, 0, 0, 0, 2'd0, 0);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 2'd0, 0);
  endtask
  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
    step(0, 0, 0, 1, 1, 1, a, d);
  endtask
  task automatic wb_rd(input logic [1:0] a);
    step(0, 0, 0, 1, 1, 0, a, 0);
  endtask

  task automatic apply_reset();
    i_reset = 1; i_valid = 1; i_sync = 1; i_data = $urandom;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = ADDR_CTRL;
    @(posedge i_clk); #1;
    model_clear();
    i_reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if ({o_valid, o_sync, o_wb_ack} !== 3'b000) begin fails++;
      $display("FAIL reset_flags got %b want 000", {o_valid, o_sync, o_wb_ack}); end
    tests++; if (o_data !== 32'd0) begin fails++;
      $display("FAIL reset_odata got %h want 0", o_data); end
    wb_rd(ADDR_CTRL);
    tests++; if (o_wb_ack !== 1'b1 || o_wb_data !== 32'd0) begin fails++;
      $display("FAIL reset_ctrl ack %b data %h want 1 0", o_wb_ack, o_wb_data); end
    wb_rd(ADDR_PERIOD);
    tests++; if (o_wb_data !== 32'd0) begin fails++;
      $display("FAIL reset_period got %h want 0", o_wb_data); end
    tests++; if (o_wb_stall !== 1'b0) begin fails++;
      $display("FAIL stall got %b want 0", o_wb_stall); end
  endtask

  task automatic test_continuous();
    logic [31:0] d, want;
    wb_wr(ADDR_PERIOD, 8); wb_wr(ADDR_POSITION, 3); wb_wr(ADDR_PIXEL, PIX); wb_wr(ADDR_CTRL, 32'h1);
    wb_rd(ADDR_PIXEL);
    tests++; if (o_wb_data !== PIX) begin fails++;
      $display("FAIL cont_pixel_rd got %h want %h", o_wb_data, PIX); end
    for (int k = 0; k < 24; k++) begin
      d = $urandom & 32'h7FFFFFFF;
      beat(k % 8 == 0, d);
      want = (k % 8 == 3) ? PIX : d;
      tests++; if (o_data !== want || o_valid !== 1'b1 || o_sync !== (k % 8 == 0)) begin fails++;
        $display("FAIL cont_beat k=%0d got %h/%b/%b want %h/1/%b", k, o_data, o_valid, o_sync, want, k % 8 == 0); end
    end
    wb_rd(ADDR_CTRL);
    tests++; if (o_wb_data !== 32'h0003_0001) begin fails++;
      $display("FAIL cont_hits got %h want 00030001", o_wb_data); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int inj, first;
    wb_wr(ADDR_CTRL, 32'hB);
    for (int r = 0; r < 2; r++) begin
      wb_wr(ADDR_CTRL, 32'h7);
      inj = 0; first = -1;
      for (int k = 0; k < 24; k++) begin
        d = $urandom & 32'h7FFFFFFF;
        beat(k % 8 == 0, d);
        if (o_data === PIX) begin inj++; if (first < 0) first = k; end
        tests++; if (o_data !== exp_data) begin fails++;
          $display("FAIL oneshot_beat r=%0d k=%0d got %h want %h", r, k, o_data, exp_data); end
      end
      tests++; if (inj != 1 || first != 3) begin fails++;
        $display("FAIL oneshot_count r=%0d got %0d@%0d want 1@3", r, inj, first); end
      wb_rd(ADDR_CTRL);
      tests++; if (o_wb_data !== (r == 0 ? 32'h0001_000B : 32'h0002_000B)) begin fails++;
        $display("FAIL oneshot_ctrl r=%0d got %h want %h", r, o_wb_data, r == 0 ? 32'h0001_000B : 32'h0002_000B); end
    end
  endtask

  task automatic test_pos_change();
    logic [31:0] d, want;
    wb_wr(ADDR_CTRL, 32'h9);
    for (int k = 0; k < 16; k++) begin
      d = $urandom & 32'h7FFFFFFF;
      if (k == 2) step(1, 0, d, 1, 1, 1, ADDR_POSITION, 5);
      else beat(k % 8 == 0, d);
      want = (k == 3 || k == 13) ? PIX : d;
      tests++; if (o_data !== want) begin fails++;
        $display("FAIL pos_change k=%0d got %h want %h", k, o_data, want); end
    end
  endtask

  task automatic test_resync();
    logic [31:0] d, want;
    wb_wr(ADDR_PERIOD, 4); wb_wr(ADDR_POSITION, 1);
    for (int k = 0; k < 12; k++) begin
      d = $urandom & 32'h7FFFFFFF;
      beat(k == 6, d);
      want = (k == 1 || k == 5 || k == 7 || k == 11) ? PIX : d;
      tests++; if (o_data !== want || o_data !== exp_data) begin fails++;
        $display("FAIL resync k=%0d got %h want %h", k, o_data, want); end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d, want;
    wb_wr(ADDR_PERIOD, 8); wb_wr(ADDR_POSITION, 3); wb_wr(ADDR_CTRL, 32'h3);
    for (int k = 0; k < 8; k++) begin
      d = $urandom & 32'h7FFFFFFF;
      if (k == 3) step(1, 0, d, 1, 1, 1, ADDR_CTRL, 32'h7);
      else beat(k == 0, d);
      tests++; if (o_data !== d) begin fails++;
        $display("FAIL arm_hit k=%0d got %h want %h", k, o_data, d); end
    end
    wb_rd(ADDR_CTRL);
    tests++; if (o_wb_data[2] !== 1'b1 || o_wb_data !== exp_rd) begin fails++;
      $display("FAIL arm_after got %h want %h", o_wb_data, exp_rd); end
    for (int k = 0; k < 8; k++) begin
      d = $urandom & 32'h7FFFFFFF;
      beat(k == 0, d);
      want = (k == 3) ? PIX : d;
      tests++; if (o_data !== want) begin fails++;
        $display("FAIL arm_next k=%0d got %h want %h", k, o_data, want); end
    end
    wb_wr(ADDR_CTRL, 32'h7);
    for (int k = 0; k < 8; k++) begin
      d = $urandom & 32'h7FFFFFFF;
      if (k == 3) step(1, 0, d, 1, 1, 1, ADDR_CTRL, 32'hB);
      else beat(k == 0, d);
      want = (k == 3) ? PIX : d;
      tests++; if (o_data !== want) begin fails++;
        $display("FAIL clr_hit k=%0d got %h want %h", k, o_data, want); end
    end
    wb_rd(ADDR_CTRL);
    tests++; if (o_wb_data !== 32'h0001_000B) begin fails++;
      $display("FAIL clr_hit_ctrl got %h want 0001000b", o_wb_data); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d, want;
    int n;
    wb_wr(ADDR_CTRL, 32'h1);
    beat(1, $urandom); idle(); beat(0, $urandom); beat(0, $urandom);
    wb_rd(ADDR_PERIOD);
    apply_reset();
    tests++; if ({o_valid, o_sync, o_wb_ack} !== 3'b000 || o_data !== 0 || o_wb_data !== 0) begin fails++;
      $display("FAIL midreset got %b %h %h want 000 0 0", {o_valid, o_sync, o_wb_ack}, o_data, o_wb_data); end
    wb_wr(ADDR_POSITION, 2); wb_wr(ADDR_PIXEL, PIX); wb_wr(ADDR_CTRL, 32'h1);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 2) == 0) idle();
      else begin
        d = $urandom & 32'h7FFFFFFF;
        beat(0, d);
        want = (n == 2) ? PIX : d;
        tests++; if (o_data !== want) begin fails++;
          $display("FAIL post_reset n=%0d got %h want %h", n, o_data, want); end
        n++;
      end
    end
    wb_rd(ADDR_POSITION);
    step(0, 0, 0, 0, 1, 0, ADDR_PERIOD, 0);
    tests++; if (o_wb_ack !== 1'b0 || o_wb_data !== 32'd2) begin fails++;
      $display("FAIL nocyc ack %b data %h want 0 2", o_wb_ack, o_wb_data); end
  endtask

  task automatic test_random();
    int c;
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      wb_wr(ADDR_PERIOD, $urandom_range(1, 10));
      wb_wr(ADDR_POSITION, $urandom_range(0, 11));
      wb_wr(ADDR_PIXEL, $urandom);
      wb_wr(ADDR_CTRL, $urandom_range(0, 15));
      for (int k = 0; k < 150; k++) begin
        c = $urandom_range(0, 19);
        if (c == 0) wb_wr(ADDR_POSITION, $urandom_range(0, 11));
        else if (c == 1) wb_wr(ADDR_CTRL, $urandom_range(0, 15));
        else if (c == 2) begin
          wb_rd(2'($urandom_range(0, 3)));
          tests++; if (o_wb_data !== exp_rd || o_wb_ack !== exp_ack) begin fails++;
            $display("FAIL rand_rd r=%0d k=%0d got %h/%b want %h/%b", r, k, o_wb_data, o_wb_ack, exp_rd, exp_ack); end
        end
        else if (c < 6) idle();
        else beat($urandom_range(0, 9) == 0, $urandom);
        tests++; if ({o_valid, o_sync, o_data} !== {exp_valid, exp_sync, exp_data}) begin fails++;
          $display("FAIL rand_px r=%0d k=%0d got %b/%b/%h want %b/%b/%h", r, k,
                   o_valid, o_sync, o_data, exp_valid, exp_sync, exp_data); end
      end
    end
  endtask

  initial begin
    model_clear();
    @(posedge i_clk); #1;
    test_reset();
    test_continuous();
    test_oneshot();
    test_pos_change();
    test_resync();
    test_simultaneous();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
